sysbus_arbiter: RTL

Two-requester arbiter sharing the single memory-side Sysbus port between the instruction-fetch cache (port p0) and the data cache (port p1). It grants the bus to one requester for an entire transaction (request beat, plus 8 write-data beats or 8 read-response beats), routes handshakes and data to the owner only, and alternates ownership round-robin when both requesters are pending. It sits between the two caches and the memory/bus model.

---
 rtl/sysbus_arbiter.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/sysbus_arbiter.sv
// -----------------------------------------------------------------------------
// sysbus_arbiter
//
// Shares one memory-side Sysbus port between two requesters: the instruction
// fetch cache (p0) and the data cache (p1). A requester owns the bus for a
// whole transaction: one request beat, then either BURST_BEATS write-data
// beats or BURST_BEATS read-response beats. Handshakes and data are routed to
// the owner only. When both requesters are pending at arbitration time, the
// port that did not win last time is chosen.
//
// Ports
//   clk                      rising-edge clock for all state
//   reset                    asynchronous reset, active low
//   pN_bus_reqcyc/req/reqtag requester N request or write-data beat
//   pN_bus_respack           requester N accepts a response beat
//   pN_bus_reqack            request beat of requester N accepted
//   pN_bus_respcyc/resp/resptag  response beat towards requester N
//   m_bus_reqcyc/req/reqtag  request beat towards memory
//   m_bus_respack            response beat accepted, towards memory
//   m_bus_reqack             memory accepted the request beat
//   m_bus_respcyc/resp/resptag   response beat from memory
//   grant                    one-hot owner {p1,p0}; 2'b00 while idle
// -----------------------------------------------------------------------------
`ifndef SYSBUS_READ
`define SYSBUS_READ  1'b1
`endif
`ifndef SYSBUS_WRITE
`define SYSBUS_WRITE 1'b0
`endif

module sysbus_arbiter #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int BURST_BEATS    = 8
) (
    input  logic                      clk,
    input  logic                      reset,

    input  logic                      p0_bus_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0] p0_bus_req,
    input  logic [BUS_TAG_WIDTH-1:0]  p0_bus_reqtag,
    input  logic                      p0_bus_respack,
    output logic                      p0_bus_reqack,
    output logic                      p0_bus_respcyc,
    output logic [BUS_DATA_WIDTH-1:0] p0_bus_resp,
    output logic [BUS_TAG_WIDTH-1:0]  p0_bus_resptag,

    input  logic                      p1_bus_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0] p1_bus_req,
    input  logic [BUS_TAG_WIDTH-1:0]  p1_bus_reqtag,
    input  logic                      p1_bus_respack,
    output logic                      p1_bus_reqack,
    output logic                      p1_bus_respcyc,
    output logic [BUS_DATA_WIDTH-1:0] p1_bus_resp,
    output logic [BUS_TAG_WIDTH-1:0]  p1_bus_resptag,

    output logic                      m_bus_reqcyc,
    output logic [BUS_DATA_WIDTH-1:0] m_bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  m_bus_reqtag,
    output logic                      m_bus_respack,
    input  logic                      m_bus_reqack,
    input  logic                      m_bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0] m_bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  m_bus_resptag,

    output logic [1:0]                grant
);

    localparam int CNT_W = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_BEATS - 1);
    localparam int OP_BIT = BUS_TAG_WIDTH - 1;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WDATA,
        RRESP
    } state_t;

    state_t             state, state_nxt;
    logic               owner, owner_nxt;           // 0 = p0, 1 = p1
    logic               last_grant, last_grant_nxt;
    logic [CNT_W-1:0]   beat_cnt, beat_cnt_nxt;
    logic               is_write, is_write_nxt;

    // Owner-selected requester signals.
    logic                      own_reqcyc;
    logic [BUS_DATA_WIDTH-1:0] own_req;
    logic [BUS_TAG_WIDTH-1:0]  own_reqtag;
    logic                      own_respack;

    assign own_reqcyc  = owner ? p1_bus_reqcyc  : p0_bus_reqcyc;
    assign own_req     = owner ? p1_bus_req     : p0_bus_req;
    assign own_reqtag  = owner ? p1_bus_reqtag  : p0_bus_reqtag;
    assign own_respack = owner ? p1_bus_respack : p0_bus_respack;

    // Tie goes to the port that did not win the previous arbitration.
    logic winner;
    assign winner = (p0_bus_reqcyc && p1_bus_reqcyc) ? ~last_grant : p1_bus_reqcyc;

    logic req_is_write;
    assign req_is_write = (own_reqtag[OP_BIT] == `SYSBUS_WRITE);

    // Direction of the data phase is keyed off the latched op bit as well as
    // the state, so a stray state value can never open both paths at once.
    logic fwd_req;
    logic fwd_rsp;
    assign fwd_req = (state == REQ) || ((state == WDATA) && is_write);
    assign fwd_rsp = (state == RRESP) && !is_write;

    // NOTE: state elements use non-blocking assignments so every register
    // samples values from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            beat_cnt   <= '0;
            is_write   <= 1'b0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            last_grant <= last_grant_nxt;
            beat_cnt   <= beat_cnt_nxt;
            is_write   <= is_write_nxt;
        end
    end

    // NOTE: every signal written in a combinational block gets a default at
    // the top; a path that leaves one unassigned would infer a latch.
    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        last_grant_nxt = last_grant;
        beat_cnt_nxt   = beat_cnt;
        is_write_nxt   = is_write;
        case (state)
            IDLE: begin
                if (p0_bus_reqcyc || p1_bus_reqcyc) begin
                    owner_nxt      = winner;
                    last_grant_nxt = winner;
                    state_nxt      = REQ;
                end
            end
            REQ: begin
                if (!own_reqcyc) begin
                    state_nxt = IDLE;            // requester gave up before ack
                end else if (m_bus_reqack) begin
                    is_write_nxt = req_is_write;
                    beat_cnt_nxt = '0;
                    state_nxt    = req_is_write ? WDATA : RRESP;
                end
            end
            WDATA: begin
                if (own_reqcyc && m_bus_reqack) begin
                    beat_cnt_nxt = beat_cnt + CNT_W'(1);
                    if (beat_cnt == LAST_BEAT) state_nxt = IDLE;
                end
            end
            RRESP: begin
                if (m_bus_respcyc && own_respack) begin
                    beat_cnt_nxt = beat_cnt + CNT_W'(1);
                    if (beat_cnt == LAST_BEAT) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Zero-latency routing between the owner and the memory side.
    always_comb begin
        m_bus_reqcyc   = 1'b0;
        m_bus_req      = '0;
        m_bus_reqtag   = '0;
        m_bus_respack  = 1'b0;
        p0_bus_reqack  = 1'b0;
        p1_bus_reqack  = 1'b0;
        p0_bus_respcyc = 1'b0;
        p1_bus_respcyc = 1'b0;
        p0_bus_resp    = '0;
        p1_bus_resp    = '0;
        p0_bus_resptag = '0;
        p1_bus_resptag = '0;
        if (fwd_req) begin
            m_bus_reqcyc = own_reqcyc;
            m_bus_req    = own_req;
            m_bus_reqtag = own_reqtag;
            if (owner) p1_bus_reqack = m_bus_reqack;
            else       p0_bus_reqack = m_bus_reqack;
        end
        if (fwd_rsp) begin
            m_bus_respack = own_respack;
            if (owner) begin
                p1_bus_respcyc = m_bus_respcyc;
                p1_bus_resp    = m_bus_resp;
                p1_bus_resptag = m_bus_resptag;
            end else begin
                p0_bus_respcyc = m_bus_respcyc;
                p0_bus_resp    = m_bus_resp;
                p0_bus_resptag = m_bus_resptag;
            end
        end
    end

    assign grant = (state == IDLE) ? 2'b00 : (owner ? 2'b10 : 2'b01);

endmodule
